// File: rtl/display_pkg.sv
// Shared constants, engine state type and address packing
// for the display write sequencer.
package display_pkg;

  localparam logic [7:0] PORT_ROW        = 8'h80;
  localparam logic [7:0] PORT_ATTR       = 8'h81;
  localparam logic [7:0] PORT_CMD        = 8'h82;
  localparam logic [7:0] PORT_STATUS     = 8'h83;
  localparam logic [7:0] PORT_CHAR_AUTO  = 8'h84;
  localparam logic [7:0] PORT_CURSOR_COL = 8'h85;

  localparam int CMD_CLEAR  = 0;
  localparam int CMD_SCROLL = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCROLL_RD,
    ST_SCROLL_WAIT,
    ST_SCROLL_WR
  } engState_t;

  function automatic logic [11:0] packAddr(
    input logic [4:0] row,
    input logic [6:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/display_write_sequencer_if.sv
// CPU port bus plus display memory port, bundled.
// master = CPU/memory side, slave = sequencer.
interface display_write_sequencer_if;
  logic [7:0]  portId;
  logic [7:0]  writeData;
  logic        writeStrobe;
  logic [7:0]  readData;
  logic [11:0] memAddr;
  logic        memEn;
  logic        memWr;
  logic [15:0] memDataIn;
  logic [15:0] memDataOut;
  logic        busy;

  modport master (
    output portId, writeData, writeStrobe, memDataOut,
    input  readData, memAddr, memEn, memWr, memDataIn, busy
  );

  modport slave (
    input  portId, writeData, writeStrobe, memDataOut,
    output readData, memAddr, memEn, memWr, memDataIn, busy
  );
endinterface

// File: rtl/display_fill_engine.sv
// Clear / scroll-up engine: walks the text buffer one cell per
// granted cycle; a withheld grant freezes state and counters.
module display_fill_engine
  import display_pkg::*;
#(
  parameter int         ROWS      = 30,
  parameter int         COLS      = 80,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startClear,
  input  logic        startScroll,
  input  logic        grant,
  input  logic [7:0]  attr,
  input  logic [15:0] memDataOut,
  output logic        busy,
  output logic        engEn,
  output logic        engWr,
  output logic [11:0] engAddr,
  output logic [15:0] engData
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0] SCR_ROW  = 5'(ROWS - 2);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  engState_t   state, nextState;
  logic [4:0]  row, nextRow;
  logic [6:0]  col, nextCol;
  logic [15:0] holdReg, nextHold;
  logic        wrapCol;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      row     <= '0;
      col     <= '0;
      holdReg <= '0;
    end else begin
      state   <= nextState;
      row     <= nextRow;
      col     <= nextCol;
      holdReg <= nextHold;
    end
  end

  assign wrapCol = (col == LAST_COL);

  always_comb begin
    nextState = state;
    nextRow   = row;
    nextCol   = col;
    nextHold  = holdReg;
    unique case (state)
      ST_IDLE: begin
        if (startClear) begin
          nextState = ST_CLEAR;
          nextRow   = '0;
          nextCol   = '0;
        end else if (startScroll) begin
          nextState = ST_SCROLL_RD;
          nextRow   = '0;
          nextCol   = '0;
        end
      end
      ST_CLEAR: begin
        if (grant) begin
          nextCol = wrapCol ? 7'd0 : col + 7'd1;
          if (wrapCol && row == LAST_ROW)
            nextState = ST_IDLE;
          else if (wrapCol)
            nextRow = row + 5'd1;
        end
      end
      ST_SCROLL_RD: begin
        if (grant) nextState = ST_SCROLL_WAIT;
      end
      ST_SCROLL_WAIT: begin
        nextHold  = memDataOut;
        nextState = ST_SCROLL_WR;
      end
      ST_SCROLL_WR: begin
        if (grant) begin
          if (wrapCol && row == SCR_ROW) begin
            // last copied cell: blank the bottom row
            nextState = ST_CLEAR;
            nextRow   = LAST_ROW;
            nextCol   = '0;
          end else begin
            nextState = ST_SCROLL_RD;
            nextCol   = wrapCol ? 7'd0 : col + 7'd1;
            if (wrapCol) nextRow = row + 5'd1;
          end
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    engEn   = 1'b0;
    engWr   = 1'b0;
    engAddr = '0;
    engData = '0;
    unique case (state)
      ST_CLEAR: begin
        engEn   = 1'b1;
        engWr   = 1'b1;
        engAddr = packAddr(row, col);
        engData = {attr, FILL_CHAR};
      end
      ST_SCROLL_RD: begin
        engEn   = 1'b1;
        engAddr = packAddr(row + 5'd1, col);
      end
      ST_SCROLL_WR: begin
        engEn   = 1'b1;
        engWr   = 1'b1;
        engAddr = packAddr(row, col);
        engData = holdReg;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/display_write_sequencer.sv
// Port decode, CPU registers and memory-port arbitration (CPU first).
// Optional cursor auto-increment: DISPLAY_WRITE_SEQUENCER_AUTOINC_EN.
module display_write_sequencer
  import display_pkg::*;
#(
  parameter int         ROWS      = 30,
  parameter int         COLS      = 80,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic clk,
  input  logic reset,
  display_write_sequencer_if.slave bus
);

  logic [4:0]  rowReg;
  logic [7:0]  attrReg;
  logic        charWr, rowWr, attrWr, cmdWr;
  logic        cpuWr, autoScroll;
  logic [11:0] cpuAddr;
  logic        startClear, startScroll;
  logic        engBusy, engEn, engWr;
  logic [11:0] engAddr;
  logic [15:0] engData;

  always_comb begin
    charWr = 1'b0;
    rowWr  = 1'b0;
    attrWr = 1'b0;
    cmdWr  = 1'b0;
    unique case (1'b1)
      bus.writeStrobe && !bus.portId[7]:
        charWr = 1'b1;
      bus.writeStrobe && bus.portId == PORT_ROW:
        rowWr = 1'b1;
      bus.writeStrobe && bus.portId == PORT_ATTR:
        attrWr = 1'b1;
      bus.writeStrobe && bus.portId == PORT_CMD:
        cmdWr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rowReg  <= '0;
      attrReg <= 8'h0F;
    end else begin
      if (rowWr)  rowReg  <= bus.writeData[4:0];
      if (attrWr) attrReg <= bus.writeData;
    end
  end

`ifdef DISPLAY_WRITE_SEQUENCER_AUTOINC_EN
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  logic [4:0] cursorRow;
  logic [6:0] cursorCol;
  logic       autoWr, colWr, atEnd;

  assign autoWr = bus.writeStrobe &&
                  bus.portId == PORT_CHAR_AUTO;
  assign colWr  = bus.writeStrobe &&
                  bus.portId == PORT_CURSOR_COL;
  assign atEnd  = cursorRow == LAST_ROW &&
                  cursorCol == LAST_COL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursorRow <= '0;
      cursorCol <= '0;
    end else begin
      if (rowWr) cursorRow <= bus.writeData[4:0];
      if (colWr) cursorCol <= bus.writeData[6:0];
      if (autoWr && cursorCol == LAST_COL) begin
        cursorCol <= '0;
        if (!atEnd) cursorRow <= cursorRow + 5'd1;
      end else if (autoWr) begin
        cursorCol <= cursorCol + 7'd1;
      end
    end
  end

  assign cpuWr      = charWr | autoWr;
  assign cpuAddr    = charWr ?
                      packAddr(rowReg, bus.portId[6:0]) :
                      packAddr(cursorRow, cursorCol);
  // auto-scroll is dropped, not queued, when the engine is busy
  assign autoScroll = autoWr && atEnd && !engBusy;
`else
  assign cpuWr      = charWr;
  assign cpuAddr    = packAddr(rowReg, bus.portId[6:0]);
  assign autoScroll = 1'b0;
`endif

  assign startClear  = cmdWr && !engBusy &&
                       bus.writeData[CMD_CLEAR];
  assign startScroll = (cmdWr && !engBusy &&
                        bus.writeData[CMD_SCROLL] &&
                        !bus.writeData[CMD_CLEAR]) ||
                       autoScroll;

  display_fill_engine #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .FILL_CHAR (FILL_CHAR)
  ) u_engine (
    .clk         (clk),
    .reset       (reset),
    .startClear  (startClear),
    .startScroll (startScroll),
    .grant       (!cpuWr),
    .attr        (attrReg),
    .memDataOut  (bus.memDataOut),
    .busy        (engBusy),
    .engEn       (engEn),
    .engWr       (engWr),
    .engAddr     (engAddr),
    .engData     (engData)
  );

  always_comb begin
    bus.memEn     = engEn;
    bus.memWr     = engWr;
    bus.memAddr   = engAddr;
    bus.memDataIn = engData;
    if (cpuWr) begin
      bus.memEn     = 1'b1;
      bus.memWr     = 1'b1;
      bus.memAddr   = cpuAddr;
      bus.memDataIn = {attrReg, bus.writeData};
    end
  end

  assign bus.busy     = engBusy;
  assign bus.readData = (bus.portId == PORT_STATUS) ?
                        {7'b0, engBusy} : 8'h00;

endmodule
